mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Parametrised N-channel arbiter in front of one single-port block-SRAM instance. It lets several masters share one memory: the CPU core, the LCD scan-out reader and a future DMA or loader. Grants are round-robin, with at most one access issued per cycle. The issuing channel is tracked through the memory's read latency so that each read response is returned, tagged, to the requesting channel only.

Parameters:
NUM_CH, 2, number of client channels (1..8)
ADDR_W, 13, memory address width
DATA_W, 8, memory data width
READ_LAT, 1, cycles from issue (mem_ce high) to mem_dout valid (1..4; 2 when the BSRAM output register is enabled)

Ports:
clk  in  1  single system clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
req  in  NUM_CH  per-channel access request, held until granted
we  in  NUM_CH  per-channel write enable (1 = write, 0 = read)
addr  in  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CH*DATA_W  per-channel write data, packed the same way
gnt  out  NUM_CH  one-hot grant; the access is issued this cycle
rvalid  out  NUM_CH  one-hot, one-cycle pulse: rdata belongs to that channel
rdata  out  DATA_W  shared read-return data
mem_ce  out  1  memory clock enable, i.e. an access is issued
mem_wre  out  1  memory write enable
mem_ad  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data

Behaviour:
- Reset (rst_n low at posedge): rr_ptr = 0, tag pipeline cleared, rvalid = 0. gnt, mem_ce and mem_wre are forced to 0 while rst_n is low.
- Arbitration is combinational from req and rr_ptr. The winner is the first requesting channel at or after rr_ptr, searching modulo NUM_CH. gnt is asserted only for the winner.
- Issue happens in the same cycle as gnt:
  - mem_ce = 1.
  - mem_ad, mem_wre and mem_din are muxed from the winner's addr, we and wdata.
  - With no request: mem_ce = 0, mem_wre = 0, mem_ad/mem_din hold their last value.
- Pointer update on any grant: rr_ptr <= winner+1, wrapping to 0 after NUM_CH-1. With no grant, rr_ptr holds.
- Client rules:
  - req, we, addr and wdata must stay stable until the cycle gnt is seen.
  - The client may drop req, or present the next access, on the cycle after gnt.
  - A channel dropping req before it is granted is legal; nothing is issued for it.
- Back-to-back: a sole requester is granted every cycle, giving full throughput.
- Read return:
  - Every read grant pushes {valid, channel id} into a READ_LAT-deep shift register.
  - At the pipeline output, rvalid[id] pulses for one cycle and rdata = mem_dout.
  - A read granted at cycle t returns at cycle t+READ_LAT.
  - Writes push valid = 0 and never produce rvalid.
- Ordering: responses return in issue order. A read issued after a write to the same address, in a later cycle, returns the new data.
- Simultaneous requests from all channels are served one per cycle in rotating order, so each channel waits at most NUM_CH-1 cycles.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced after reset.
- NUM_CH = 1: pure pass-through. gnt = req, ID width is 1.

Optional Feature:
MEM_ARB_CH0_PRIO_EN
- Defined: channel 0 (CPU) wins whenever req[0] is high. The round-robin applies only among channels 1..NUM_CH-1, and rr_ptr is not updated on a channel-0 grant.
- Undefined: plain round-robin over all channels, as above.

Decomposition:
- Package mem_arb_pkg holds:
  - function clog2_min1 (ID width, at least 1)
  - typedef ch_id_t
  - typedef rd_tag_t {logic valid; ch_id_t id;}
  - constants MAX_CH = 8 and MAX_READ_LAT = 4
- Sub-module rr_picker: combinational first-set-at-or-after-pointer search over NUM_CH. It is instantiated once and is also reusable for the LCD/VRAM path.
- The tag shift register stays inline in mem_arbiter.

Test Plan:
1. Reset with req=2'b11 held → gnt=0, mem_ce=0. First grant after release is ch0, next cycle ch1, then alternating 0,1,0,1.
2. ch0 writes 8'hA5 to 13'h0100, then ch1 reads 13'h0100 (READ_LAT=1) → rvalid=2'b10 with rdata=8'hA5 exactly 1 cycle after ch1's gnt; rvalid[0] never pulses.
3. NUM_CH=4, READ_LAT=2, all four read distinct addresses 0..3 preloaded 8'h10..8'h13 → gnt order 0,1,2,3. rvalid pulses 1,2,4,8 two cycles later with rdata 10,11,12,13 in consecutive cycles.
4. Sole requester ch1 issues 16 back-to-back reads → gnt[1] high for 16 consecutive cycles and 16 consecutive rvalid pulses.
5. Two reads are in flight (READ_LAT=2) and rst_n is pulsed low for 1 cycle → no rvalid after reset, rr_ptr=0, next grant is ch0.
6. With MEM_ARB_CH0_PRIO_EN defined, req=3'b111 held for 6 cycles → ch0 granted every cycle and ch1/ch2 starve. Dropping req[0] → ch1 then ch2 alternate.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the block-SRAM arbiter and its pointer search.
package mem_arb_pkg;

  localparam int MAX_CH       = 8;
  localparam int MAX_READ_LAT = 4;

  // Channel-id width, never zero so a single-channel build still has a field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CH_ID_W = clog2_min1(MAX_CH);

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_if.sv
// Client and memory-side bus of mem_arbiter; slave is the arbiter, master the clients/memory.
interface mem_arb_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     mem_ce;
  logic                     mem_wre;
  logic [ADDR_W-1:0]        mem_ad;
  logic [DATA_W-1:0]        mem_din;
  logic [DATA_W-1:0]        mem_dout;

  modport slave (
    input  req, we, addr, wdata, mem_dout,
    output gnt, rvalid, rdata, mem_ce, mem_wre, mem_ad, mem_din
  );

  modport master (
    output req, we, addr, wdata, mem_dout,
    input  gnt, rvalid, rdata, mem_ce, mem_wre, mem_ad, mem_din
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational search for the first set request bit at or after ptr, modulo NUM_CH.
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = {ID_W{1'b0}};
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if ((j == ((int'(ptr) + off) % NUM_CH)) && req[j]) begin
          found = 1'b1;
          idx   = ID_W'(j);
        end else begin
          found = found;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin N-channel arbiter for one single-port BSRAM with tagged read return.
// Optional build macro MEM_ARB_CH0_PRIO_EN gives channel 0 absolute priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input logic      clk,
  input logic      rst_n,
  mem_arb_if.slave bus
);

  localparam int ID_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] pick_req_s;
  logic              pick_found_s;
  logic [ID_W-1:0]   pick_idx_s;
  logic              prio_s;
  logic              grant_s;
  logic              rr_upd_s;
  logic [ID_W-1:0]   win_s;
  logic [ID_W-1:0]   ptr_nxt_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [NUM_CH-1:0] gnt_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_ad_s;
  logic [DATA_W-1:0] win_din_s;
  logic [ADDR_W-1:0] last_ad_r;
  logic [DATA_W-1:0] last_din_r;
  logic [NUM_CH-1:0] rvalid_s;
  rd_tag_t           tag_r [READ_LAT];

  // Channel 0 leaves the rotation when it has absolute priority.
  always_comb begin
    pick_req_s = bus.req;
`ifdef MEM_ARB_CH0_PRIO_EN
    pick_req_s[0] = 1'b0;
    prio_s        = bus.req[0];
`else
    prio_s        = 1'b0;
`endif
  end

  rr_picker #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_picker (
    .req   (pick_req_s),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Winner select, grant decode and issue mux.
  always_comb begin
    grant_s   = rst_n && (prio_s || pick_found_s);
    win_s     = prio_s ? {ID_W{1'b0}} : pick_idx_s;
    rr_upd_s  = grant_s && !prio_s;
    ptr_nxt_s = (win_s == ID_W'(NUM_CH - 1)) ? {ID_W{1'b0}} : win_s + ID_W'(1);
    gnt_s     = {NUM_CH{1'b0}};
    win_we_s  = 1'b0;
    win_ad_s  = {ADDR_W{1'b0}};
    win_din_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_s == ID_W'(i)) begin
        gnt_s[i]  = grant_s;
        win_we_s  = bus.we[i];
        win_ad_s  = bus.addr[i*ADDR_W +: ADDR_W];
        win_din_s = bus.wdata[i*DATA_W +: DATA_W];
      end else begin
        gnt_s[i]  = 1'b0;
      end
    end
  end

  // Decode the tag leaving the latency pipe into a one-hot return strobe.
  always_comb begin
    rvalid_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_n && tag_r[READ_LAT-1].valid && (tag_r[READ_LAT-1].id == ch_id_t'(i))) begin
        rvalid_s[i] = 1'b1;
      end else begin
        rvalid_s[i] = 1'b0;
      end
    end
  end

  assign bus.gnt     = gnt_s;
  assign bus.mem_ce  = grant_s;
  assign bus.mem_wre = grant_s & win_we_s;
  assign bus.mem_ad  = grant_s ? win_ad_s : last_ad_r;
  assign bus.mem_din = grant_s ? win_din_s : last_din_r;
  assign bus.rvalid  = rvalid_s;
  assign bus.rdata   = bus.mem_dout;

  // Pointer, idle-hold registers and the read-tag pipe that mirrors memory latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r   <= {ID_W{1'b0}};
      last_ad_r  <= {ADDR_W{1'b0}};
      last_din_r <= {DATA_W{1'b0}};
      for (int i = 0; i < READ_LAT; i++) begin
        tag_r[i] <= '{valid: 1'b0, id: {CH_ID_W{1'b0}}};
      end
    end else begin
      if (rr_upd_s) begin
        rr_ptr_r <= ptr_nxt_s;
      end
      if (grant_s) begin
        last_ad_r  <= win_ad_s;
        last_din_r <= win_din_s;
      end
      tag_r[0] <= '{valid: grant_s && !win_we_s, id: ch_id_t'(win_s)};
      for (int i = 1; i < READ_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (4 channels, 2-cycle read latency) against a rule-level model.
module tb_mem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int AWT = NCH * AW;
  localparam int DWT = NCH * DW;
`ifdef MEM_ARB_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam logic [NCH-1:0] ONE = 4'b0001;

  typedef struct {
    int            due;
    int            ch;
    logic [DW-1:0] data;
  } pend_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   m_ptr;
  int   m_win;
  logic [AW-1:0]  m_last_ad;
  bit             m_last_valid;
  logic [DW-1:0]  model_mem [0:8191];
  pend_t          pend [$];
  logic [NCH-1:0] obs_gnt;
  int             g_cnt [NCH];
  int             rv_any;

  mem_arb_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BSRAM: writes land at the issue edge, reads emerge LAT cycles later.
  logic [DW-1:0] tb_mem [0:8191];
  logic [DW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    if (bus.mem_ce && bus.mem_wre) tb_mem[bus.mem_ad] <= bus.mem_din;
    mpipe[0] <= (bus.mem_ce && !bus.mem_wre) ? tb_mem[bus.mem_ad] : {DW{1'bx}};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mem_dout = mpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bit_of(input logic [NCH-1:0] v, input int c);
    return ((v >> c) & ONE) != {NCH{1'b0}};
  endfunction

  function automatic logic [AW-1:0] ch_addr(input int c);
    return AW'(bus.addr >> (c * AW));
  endfunction

  function automatic logic [DW-1:0] ch_wdata(input int c);
    return DW'(bus.wdata >> (c * DW));
  endfunction

  // Winner by the arbitration rule: first requester at or after ptr, ch0 first if prioritised.
  function automatic int model_pick(input logic [NCH-1:0] r, input int ptr);
    if (PRIO && bit_of(r, 0)) return 0;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (ptr + k) % NCH;
      if (!(PRIO && c == 0) && bit_of(r, c)) return c;
    end
    return -1;
  endfunction

  task automatic set_ch(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NCH-1:0] m;
    m = ONE << c;
    bus.req   = bus.req | m;
    bus.we    = w ? (bus.we | m) : (bus.we & ~m);
    bus.addr  = (bus.addr & ~(AWT'({AW{1'b1}}) << (c * AW))) | (AWT'(a) << (c * AW));
    bus.wdata = (bus.wdata & ~(DWT'({DW{1'b1}}) << (c * DW))) | (DWT'(d) << (c * DW));
  endtask

  task automatic drop_ch(input int c);
    bus.req = bus.req & ~(ONE << c);
  endtask

  // One clock: check every DUT output against the model, advance the model, move to next negedge.
  task automatic cycle_check();
    int             win;
    logic [NCH-1:0] eg;
    logic [NCH-1:0] erv;
    logic [DW-1:0]  erd;
    logic [AW-1:0]  a;
    bit             w;
    #1;
    win = rst_n ? model_pick(bus.req, m_ptr) : -1;
    eg  = (win >= 0) ? (ONE << win) : {NCH{1'b0}};
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("mem_ce", 32'(bus.mem_ce), (win >= 0) ? 32'd1 : 32'd0);
    erv = {NCH{1'b0}};
    erd = {DW{1'b0}};
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (rst_n) begin
        erv = ONE << pend[0].ch;
        erd = pend[0].data;
      end
      void'(pend.pop_front());
    end
    chk("rvalid", 32'(bus.rvalid), 32'(erv));
    if (erv != {NCH{1'b0}}) chk("rdata", 32'(bus.rdata), 32'(erd));
    obs_gnt = bus.gnt;
    for (int c = 0; c < NCH; c++) if (bit_of(bus.gnt, c)) g_cnt[c]++;
    if (bus.rvalid != {NCH{1'b0}}) rv_any++;
    if (win >= 0) begin
      a = ch_addr(win);
      w = bit_of(bus.we, win);
      chk("mem_wre", 32'(bus.mem_wre), 32'(w));
      chk("mem_ad", 32'(bus.mem_ad), 32'(a));
      if (w) begin
        chk("mem_din", 32'(bus.mem_din), 32'(ch_wdata(win)));
        model_mem[a] = ch_wdata(win);
      end else begin
        pend.push_back('{due: cyc + LAT, ch: win, data: model_mem[a]});
      end
      m_last_ad    = a;
      m_last_valid = 1'b1;
      if (!(PRIO && win == 0)) m_ptr = (win + 1) % NCH;
    end else begin
      chk("mem_wre_idle", 32'(bus.mem_wre), 32'd0);
      if (m_last_valid) chk("mem_ad_hold", 32'(bus.mem_ad), 32'(m_last_ad));
    end
    if (!rst_n) begin
      m_ptr        = 0;
      m_last_valid = 1'b0;
      pend.delete();
    end
    m_win = win;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req = {NCH{1'b0}};
    repeat (n) cycle_check();
  endtask

  // Run until every posted request has been granted, retiring each winner's request.
  task automatic serve(input int budget);
    int n;
    n = 0;
    while (bus.req != {NCH{1'b0}} && n < budget) begin
      cycle_check();
      if (m_win >= 0) drop_ch(m_win);
      n++;
    end
    chk("serve_drained", 32'(bus.req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; m_ptr = 0; m_win = -1;
    m_last_ad = {AW{1'b0}}; m_last_valid = 1'b0; rv_any = 0;
    for (int c = 0; c < NCH; c++) g_cnt[c] = 0;
    rst_n = 1'b0;
    bus.req = {NCH{1'b0}}; bus.we = {NCH{1'b0}};
    bus.addr = {AWT{1'b0}}; bus.wdata = {DWT{1'b0}};

    // Reset with every channel requesting: nothing may be granted or issued.
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, AW'(c + 64), DW'(8'h80 + c));
    repeat (2) cycle_check();
    chk("reset_mem_ce", 32'(bus.mem_ce), 32'd0);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    rst_n = 1'b1;
    drop_ch(2);
    drop_ch(3);
    cycle_check();
    chk("first_gnt_after_reset", 32'(obs_gnt), 32'd1);
    repeat (3) cycle_check();
    idle(1);

    // Preload 0..31 through ch0 as a sole back-to-back writer.
    for (int i = 0; i < 32; i++) begin
      bus.req = {NCH{1'b0}};
      set_ch(0, 1'b1, AW'(i), 8'h10 + DW'(i));
      cycle_check();
    end
    idle(1);

    // Write then read of the same address from another channel.
    set_ch(0, 1'b1, 13'h0100, 8'hA5);
    cycle_check();
    drop_ch(0);
    set_ch(1, 1'b0, 13'h0100, 8'h00);
    cycle_check();
    drop_ch(1);
    idle(LAT + 2);

    // All channels read distinct addresses at once.
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, AW'(c), 8'h00);
    serve(2 * NCH);
    idle(LAT + 2);

    // Sole requester ch1: 16 back-to-back reads.
    for (int c = 0; c < NCH; c++) g_cnt[c] = 0;
    rv_any = 0;
    for (int i = 0; i < 16; i++) begin
      bus.req = {NCH{1'b0}};
      set_ch(1, 1'b0, AW'(i), 8'h00);
      cycle_check();
    end
    idle(LAT + 2);
    chk("b2b_gnt_count", 32'(g_cnt[1]), 32'd16);
    chk("b2b_rvalid_count", 32'(rv_any), 32'd16);

    // Reset pulse with two reads in flight: none may return, next grant is ch0.
    set_ch(2, 1'b0, 13'd5, 8'h00);
    cycle_check();
    set_ch(2, 1'b0, 13'd6, 8'h00);
    cycle_check();
    drop_ch(2);
    rst_n = 1'b0;
    cycle_check();
    rst_n = 1'b1;
    rv_any = 0;
    repeat (LAT + 1) cycle_check();
    chk("rvalid_after_reset", 32'(rv_any), 32'd0);
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, AW'(c + 8), 8'h00);
    cycle_check();
    chk("gnt_after_reset", 32'(obs_gnt), 32'd1);
    drop_ch(m_win);
    serve(2 * NCH);
    idle(LAT + 2);

`ifdef MEM_ARB_CH0_PRIO_EN
    // Channel 0 starves the others while it requests.
    for (int c = 0; c < NCH; c++) g_cnt[c] = 0;
    for (int c = 0; c < 3; c++) set_ch(c, 1'b0, AW'(c + 20), 8'h00);
    repeat (6) cycle_check();
    chk("prio_ch0_count", 32'(g_cnt[0]), 32'd6);
    chk("prio_ch1_starved", 32'(g_cnt[1]), 32'd0);
    drop_ch(0);
    repeat (4) cycle_check();
    chk("prio_ch1_after_drop", 32'(g_cnt[1]), 32'd2);
    chk("prio_ch2_after_drop", 32'(g_cnt[2]), 32'd2);
    idle(LAT + 2);
`endif

    // Random traffic obeying the hold-until-granted rule.
    repeat (400) begin
      for (int c = 0; c < NCH; c++) begin
        if (!bit_of(bus.req, c)) begin
          if ($urandom_range(0, 1) == 1)
            set_ch(c, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 31)), DW'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          drop_ch(c);
        end
      end
      cycle_check();
      if (m_win >= 0) drop_ch(m_win);
    end
    idle(LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
